// File: rtl/vend_pkg.sv
// Shared types and constants for the newspaper vending controller.
package vend_pkg;

  localparam int unsigned COIN_W  = 2;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned PRICE   = 15;

  // Coin-acceptor codes; 2'b11 is an invalid code and never credits.
  localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
  localparam logic [COIN_W-1:0] COIN_5    = 2'b01;
  localparam logic [COIN_W-1:0] COIN_10   = 2'b10;

  // Credit states; DISP is the one-cycle sale state.
  typedef enum logic [STATE_W-1:0] {
    S0   = 2'd0,
    S5   = 2'd1,
    S10  = 2'd2,
    DISP = 2'd3
  } state_t;

endpackage

// File: rtl/coin_edge_detect.sv
// Turns the level coin code into single-cycle insert pulses: a valid code
// counts only when the previous sample was idle (00).
module coin_edge_detect
  import vend_pkg::*;
(
  input  logic [COIN_W-1:0] coin,
  input  logic              clock,
  input  logic              reset,
  output logic              ins5,
  output logic              ins10
);

  logic [COIN_W-1:0] prev_q;

  // Previous-sample register; an 11 sample also blocks the next insert.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_q <= COIN_NONE;
    else       prev_q <= coin;
  end

  // Insert pulses, evaluated against the value sampled at the coming edge.
  assign ins5  = (prev_q == COIN_NONE) && (coin == COIN_5);
  assign ins10 = (prev_q == COIN_NONE) && (coin == COIN_10);

endmodule

// File: rtl/newspaper_vend_ctrl.sv
// Newspaper vending controller: accumulates 5c/10c inserts and strobes the
// dispenser for one clock once 15c or more is credited. Overpay is forfeited.
module newspaper_vend_ctrl
  import vend_pkg::*;
(
  input  logic [COIN_W-1:0] coin,
  input  logic              clock,
  input  logic              reset,
  output logic              newspaper
);

  state_t state_q;
  state_t state_d;
  logic   ins5;
  logic   ins10;

  coin_edge_detect u_edge (
    .coin  (coin),
    .clock (clock),
    .reset (reset),
    .ins5  (ins5),
    .ins10 (ins10)
  );

  // State and strobe registers; reset discards any accumulated credit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S0;
      newspaper <= 1'b0;
    end else begin
      state_q   <= state_d;
      newspaper <= (state_d == DISP);
    end
  end

  // Next-state logic; an insert seen while in DISP credits the next sale.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0: begin
        if (ins5)       state_d = S5;
        else if (ins10) state_d = S10;
      end
      S5: begin
        if (ins5)       state_d = S10;
        else if (ins10) state_d = DISP;
      end
      S10: begin
        if (ins5 || ins10) state_d = DISP;
      end
      DISP: begin
        if (ins5)       state_d = S5;
        else if (ins10) state_d = S10;
        else            state_d = S0;
      end
      default: state_d = S0;
    endcase
  end

endmodule

// File: tb/tb_newspaper_vend_ctrl.sv
// Directed bench for newspaper_vend_ctrl with hand-computed expectations.
module tb_newspaper_vend_ctrl;
  import vend_pkg::*;

  logic [1:0] coin;
  logic       clock;
  logic       reset;
  logic       newspaper;

  int checks   = 0;
  int failures = 0;

  newspaper_vend_ctrl dut (
    .coin      (coin),
    .clock     (clock),
    .reset     (reset),
    .newspaper (newspaper)
  );

  initial begin
    clock = 1'b0;
    forever #20 clock = ~clock;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a coin code mid-cycle, let one rising edge sample it, then check.
  task automatic step(input logic [1:0] c, input logic exp_np, input logic [1:0] exp_st,
                      input string tag);
    @(negedge clock);
    coin = c;
    @(posedge clock);
    #1;
    check({tag, ".np"}, 8'(newspaper), 8'(exp_np));
    check({tag, ".st"}, 8'(dut.state_q), 8'(exp_st));
  endtask

  // Mid-cycle reset; state must clear without waiting for a clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clock);
    coin  = 2'b00;
    #5 reset = 1'b1;
    #1;
    check({tag, ".rst_np"}, 8'(newspaper), 8'd0);
    check({tag, ".rst_st"}, 8'(dut.state_q), 8'(S0));
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    coin  = 2'b00;
    reset = 1'b1;
    #25;
    check("reset.np", 8'(newspaper), 8'd0);
    check("reset.st", 8'(dut.state_q), 8'(S0));
    #25 reset = 1'b0;
    step(2'b00, 1'b0, S0, "idle0");
    step(2'b00, 1'b0, S0, "idle1");

    // Three 5c inserts with idle gaps
    step(2'b01, 1'b0, S5,   "t5a");
    step(2'b00, 1'b0, S5,   "t5a_g1");
    step(2'b00, 1'b0, S5,   "t5a_g2");
    step(2'b01, 1'b0, S10,  "t5b");
    step(2'b00, 1'b0, S10,  "t5b_g1");
    step(2'b00, 1'b0, S10,  "t5b_g2");
    step(2'b01, 1'b1, DISP, "t5c");
    step(2'b00, 1'b0, S0,   "t5c_end");
    step(2'b00, 1'b0, S0,   "t5c_idle");

    // 5 then 10
    step(2'b01, 1'b0, S5,   "f10a");
    step(2'b00, 1'b0, S5,   "f10a_g");
    step(2'b10, 1'b1, DISP, "f10b");
    step(2'b00, 1'b0, S0,   "f10b_end");

    // 10 then 10, no residual credit
    step(2'b10, 1'b0, S10,  "tt_a");
    step(2'b00, 1'b0, S10,  "tt_a_g");
    step(2'b10, 1'b1, DISP, "tt_b");
    step(2'b00, 1'b0, S0,   "tt_b_end");
    step(2'b01, 1'b0, S5,   "tt_5");
    step(2'b00, 1'b0, S5,   "tt_5_g");
    pulse_reset("tt");

    // Held 01 counts once
    step(2'b01, 1'b0, S5,   "hold1");
    step(2'b01, 1'b0, S5,   "hold2");
    step(2'b01, 1'b0, S5,   "hold3");
    step(2'b01, 1'b0, S5,   "hold4");
    step(2'b00, 1'b0, S5,   "hold_g");
    step(2'b01, 1'b0, S10,  "hold_b");
    step(2'b00, 1'b0, S10,  "hold_b_g");
    step(2'b01, 1'b1, DISP, "hold_c");
    step(2'b00, 1'b0, S0,   "hold_end");

    // Invalid 11 never credits and does not arm the next code
    step(2'b11, 1'b0, S0,   "inv1");
    step(2'b00, 1'b0, S0,   "inv_g");
    step(2'b11, 1'b0, S0,   "inv2");
    step(2'b01, 1'b0, S0,   "inv_then5");
    step(2'b00, 1'b0, S0,   "inv_g2");

    // 01 -> 10 without an idle in between is one insert
    step(2'b01, 1'b0, S5,   "chg_a");
    step(2'b10, 1'b0, S5,   "chg_b");
    step(2'b00, 1'b0, S5,   "chg_g");

    // Sale completes, then code changes directly during DISP: not an insert
    step(2'b10, 1'b1, DISP, "dsp_a");
    step(2'b01, 1'b0, S0,   "dsp_nochg");
    step(2'b00, 1'b0, S0,   "dsp_g");
    step(2'b01, 1'b0, S5,   "dsp_5");
    step(2'b00, 1'b0, S5,   "dsp_5g");
    step(2'b10, 1'b1, DISP, "dsp_10");
    step(2'b00, 1'b0, S0,   "dsp_end");

    // Reset in S10 drops credit; one 5c then gives no pulse
    step(2'b10, 1'b0, S10,  "rs_a");
    step(2'b00, 1'b0, S10,  "rs_g");
    pulse_reset("rs");
    step(2'b01, 1'b0, S5,   "rs_5");
    step(2'b00, 1'b0, S5,   "rs_5g");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
